// File: rtl/epl_row_encode_chk_if.sv
// rtl/epl_row_encode_chk_if.sv - handshake/data bundle for the row-select encoder checker
// Optional compare port set is built only when EPL_ROWENC_CMP_EN is defined.
`ifndef ADDR_AX
`define ADDR_AX 3
`endif
`ifndef ADDR_AXO
`define ADDR_AXO 8
`endif

interface epl_row_encode_chk_if #(
  parameter int AX   = `ADDR_AX,
  parameter int AXO  = `ADDR_AXO,
  parameter int CNTW = 8
);
  logic            vld_i;
  logic            rdy_o;
  logic [AXO-1:0]  pArx_i;
  logic            vld_o;
  logic            rdy_i;
  logic [AX-1:0]   pAr_o;
  logic            zhot_o;
  logic            mhot_o;
  logic            errclr_i;
  logic [CNTW-1:0] errcnt_o;
`ifdef EPL_ROWENC_CMP_EN
  logic [AX-1:0]   pArExp_i;
  logic            mism_o;

  modport slave (
    input  vld_i, pArx_i, pArExp_i, rdy_i, errclr_i,
    output rdy_o, vld_o, pAr_o, zhot_o, mhot_o, mism_o, errcnt_o
  );
  modport master (
    output vld_i, pArx_i, pArExp_i, rdy_i, errclr_i,
    input  rdy_o, vld_o, pAr_o, zhot_o, mhot_o, mism_o, errcnt_o
  );
`else
  modport slave (
    input  vld_i, pArx_i, rdy_i, errclr_i,
    output rdy_o, vld_o, pAr_o, zhot_o, mhot_o, errcnt_o
  );
  modport master (
    output vld_i, pArx_i, rdy_i, errclr_i,
    input  rdy_o, vld_o, pAr_o, zhot_o, mhot_o, errcnt_o
  );
`endif
endinterface

// File: rtl/epl_row_encode_chk.sv
// rtl/epl_row_encode_chk.sv - one-hot row-select to binary encoder with zero/multi-hot checks
// Two-stage valid/ready pipeline; EPL_ROWENC_CMP_EN adds expected-address compare.
module epl_row_encode_chk #(
  parameter int AX   = `ADDR_AX,
  parameter int AXO  = `ADDR_AXO,
  parameter int CNTW = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  epl_row_encode_chk_if.slave bus
);

  logic            r_a_vld;
  logic [AXO-1:0]  r_a_vec;
  logic            r_b_vld;
  logic [AX-1:0]   r_b_addr;
  logic            r_b_zhot;
  logic            r_b_mhot;
  logic [CNTW-1:0] r_errcnt;

  logic            w_b_adv;
  logic            w_a_mv;
  logic            w_rdy;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic [AX-1:0]   w_enc;
  logic            w_zhot;
  logic            w_mhot;
  logic            w_err;

  assign w_b_adv    = !r_b_vld || bus.rdy_i;
  assign w_a_mv     = r_a_vld && w_b_adv;
  assign w_rdy      = !rst_i && (!r_a_vld || w_b_adv);
  assign w_in_xfer  = bus.vld_i && w_rdy;
  assign w_out_xfer = r_b_vld && bus.rdy_i;

  // Scan high to low so the lowest set bit wins on multi-hot input.
  always_comb begin
    w_enc = '0;
    for (int i = AXO - 1; i >= 0; i--) begin
      if (r_a_vec[i]) w_enc = AX'(i);
    end
  end

  assign w_zhot = (r_a_vec == '0);
  assign w_mhot = |(r_a_vec & (r_a_vec - {{(AXO-1){1'b0}}, 1'b1}));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a_vld <= 1'b0;
      r_a_vec <= '0;
    end else if (w_in_xfer) begin
      r_a_vld <= 1'b1;
      r_a_vec <= bus.pArx_i;
    end else if (w_a_mv) begin
      r_a_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_b_vld  <= 1'b0;
      r_b_addr <= '0;
      r_b_zhot <= 1'b0;
      r_b_mhot <= 1'b0;
    end else if (w_a_mv) begin
      r_b_vld  <= 1'b1;
      r_b_addr <= w_enc;
      r_b_zhot <= w_zhot;
      r_b_mhot <= w_mhot;
    end else if (w_out_xfer) begin
      r_b_vld  <= 1'b0;
    end
  end

`ifdef EPL_ROWENC_CMP_EN
  logic [AX-1:0] r_a_exp;
  logic          r_b_mism;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a_exp  <= '0;
      r_b_mism <= 1'b0;
    end else begin
      if (w_in_xfer) r_a_exp <= bus.pArExp_i;
      if (w_a_mv)    r_b_mism <= (w_enc != r_a_exp);
    end
  end

  assign bus.mism_o = r_b_mism;
  assign w_err      = r_b_zhot || r_b_mhot || r_b_mism;
`else
  assign w_err      = r_b_zhot || r_b_mhot;
`endif

  // Clear beats a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.errclr_i) begin
      r_errcnt <= '0;
    end else if (w_out_xfer && w_err && (r_errcnt != {CNTW{1'b1}})) begin
      r_errcnt <= r_errcnt + 1'b1;
    end
  end

  assign bus.rdy_o    = w_rdy;
  assign bus.vld_o    = r_b_vld;
  assign bus.pAr_o    = r_b_addr;
  assign bus.zhot_o   = r_b_zhot;
  assign bus.mhot_o   = r_b_mhot;
  assign bus.errcnt_o = r_errcnt;

endmodule
